pll_supervisor: RTL and testbench

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_supervisor.sv | 192 +++++++++++++++++++
 tb/tb_pll_supervisor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// rtl/pll_supervisor_pkg.sv - shared state encoding and counter-width helper for pll_supervisor
//
// Purpose: holds the supervisor FSM state type and the function that sizes
// every counter from its terminal value so that no counter can wrap.
// Ports: none (package).

package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST  = 3'd0,
        ST_WAIT    = 3'd1,
        ST_FILTER  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    localparam int          RELOCK_W   = 8;
    localparam logic [7:0]  RELOCK_MAX = 8'hFF;

    // Bits needed to hold every value 0..max_val; never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
//
// Purpose: brings an asynchronous level into the clk_i domain.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, clears both flops
//   d_i    - asynchronous input level
//   q_o    - synchronised level, two clk_i edges of latency

module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - PLL reset sequencing, lock filtering and staged downstream reset release
//
// Purpose: pulses the PLL reset, waits for a filtered lock, releases the
// downstream resets one stage at a time, and re-runs the sequence on loss of
// lock. Repeated lock timeouts park the block in FAULT until rst.
// Ports:
//   clkin        - board oscillator, every flop on its rising edge
//   rst          - synchronous active-high reset
//   locked       - PLL lock indicator, asynchronous to clkin
//   pll_rst      - PLL RST pin drive, active-high
//   rst_out      - staged downstream resets, active-high, bit 0 released first
//   ready        - high only in RUN
//   fault        - high only in FAULT
//   relock_count - loss-of-lock events since rst, saturating at 255

module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_FILTER  = 1024,
    parameter int MAX_RETRY    = 4,
    parameter int N_RESETS     = 3,
    parameter int STAGE_GAP    = 8
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                locked,
    output logic                pll_rst,
    output logic [N_RESETS-1:0] rst_out,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int PW = cnt_w(RST_PULSE);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int FW = cnt_w(LOCK_FILTER);
    localparam int GW = cnt_w(STAGE_GAP);
    localparam int RW = cnt_w(MAX_RETRY);

    // Terminal values: each counter stops at its *_LAST and is cleared on the
    // state change, so it never reaches the value that would wrap.
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] FLT_LAST   = FW'(LOCK_FILTER - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    // rst_out on the first RELEASE cycle: only stage 0 released.
    localparam logic [N_RESETS-1:0] FIRST_RELEASE = ~N_RESETS'(1);

    logic                locked_s;
    state_e              state_q;
    logic [PW-1:0]       pulse_q;
    logic [TW-1:0]       tmo_q;
    logic [FW-1:0]       flt_q;
    logic [GW-1:0]       gap_q;
    logic [RW-1:0]       retry_q;
    logic                pll_rst_q;
    logic [N_RESETS-1:0] rst_out_q;
    logic                ready_q;
    logic                fault_q;
    logic [RELOCK_W-1:0] relock_q;
    logic [RELOCK_W-1:0] relock_d;

    sync_2ff u_sync_locked (
        .clk_i (clkin),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    always_comb begin
        relock_d = relock_q;
        if (relock_q != RELOCK_MAX) begin
            relock_d = relock_q + 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q   <= ST_PLLRST;
            pulse_q   <= '0;
            tmo_q     <= '0;
            flt_q     <= '0;
            gap_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    pll_rst_q <= 1'b1;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                    if (pulse_q == PULSE_LAST) begin
                        state_q   <= ST_WAIT;
                        pll_rst_q <= 1'b0;
                        pulse_q   <= '0;
                        tmo_q     <= '0;
                    end else begin
                        pulse_q <= pulse_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (locked_s) begin
                        state_q <= ST_FILTER;
                        flt_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        retry_q   <= retry_q + 1'b1;
                        pulse_q   <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RETRY_LAST) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_PLLRST;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_FILTER: begin
                    if (!locked_s) begin
                        state_q <= ST_WAIT;
                        flt_q   <= '0;
                        tmo_q   <= '0;
                    end else if (flt_q == FLT_LAST) begin
                        state_q   <= ST_RELEASE;
                        rst_out_q <= FIRST_RELEASE;
                        gap_q     <= '0;
                    end else begin
                        flt_q <= flt_q + 1'b1;
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    if (!locked_s) begin
                        state_q   <= ST_PLLRST;
                        pulse_q   <= '0;
                        pll_rst_q <= 1'b1;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                        relock_q  <= relock_d;
                    end else if (state_q == ST_RELEASE) begin
                        if (rst_out_q == '0) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end else if (gap_q == GAP_LAST) begin
                            // Shifting left clears the next stage up; ones
                            // above it stay asserted.
                            rst_out_q <= rst_out_q << 1;
                            gap_q     <= '0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    pll_rst_q <= 1'b1;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b1;
                end

                default: begin
                    state_q   <= ST_PLLRST;
                    pulse_q   <= '0;
                    pll_rst_q <= 1'b1;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst      = pll_rst_q;
    assign rst_out      = rst_out_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb/tb_pll_supervisor.sv - directed self-checking bench for pll_supervisor

module tb_pll_supervisor;

    localparam int C_BIT0     = 0;
    localparam int C_BIT1     = 1;
    localparam int C_BIT2     = 2;
    localparam int C_READY    = 3;
    localparam int C_PLL_HI   = 4;
    localparam int C_PLL_LO   = 5;
    localparam int C_FAULT    = 6;
    localparam int C_ALL_ONES = 7;
    localparam int C_READY_LO = 8;
    localparam int BUDGET     = 400;

    logic       clkin = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    bit loop_ok;

    always #20 clkin = ~clkin;

    pll_supervisor #(
        .RST_PULSE    (4),
        .LOCK_TIMEOUT (100),
        .LOCK_FILTER  (8),
        .MAX_RETRY    (3),
        .N_RESETS     (3),
        .STAGE_GAP    (2)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            C_BIT0:     return rst_out[0] === 1'b0;
            C_BIT1:     return rst_out[1] === 1'b0;
            C_BIT2:     return rst_out[2] === 1'b0;
            C_READY:    return ready === 1'b1;
            C_PLL_HI:   return pll_rst === 1'b1;
            C_PLL_LO:   return pll_rst === 1'b0;
            C_FAULT:    return fault === 1'b1;
            C_ALL_ONES: return rst_out === 3'b111;
            C_READY_LO: return ready === 1'b0;
            default:    return 1'b0;
        endcase
    endfunction

    // Negedges until the condition holds; BUDGET means it never came.
    task automatic wait_cond(input int which, output int cycles);
        cycles = 0;
        while (!cond(which) && cycles < BUDGET) begin
            @(negedge clkin);
            cycles++;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clkin);
        rst    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cold start: reset values, then a 4-cycle PLL pulse and staged release.
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clkin);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_rst_out", rst_out, 3'b111);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_relock", relock_count, 0);
        rst = 1'b0;
        wait_cond(C_PLL_LO, n);
        check("cold_pllrst_width", n, 4);
        repeat (16) @(negedge clkin);
        check("cold_prelock_rst_out", rst_out, 3'b111);
        locked = 1'b1;
        wait_cond(C_BIT0, n);
        check("cold_bit0_latency", n, 11);
        check("cold_bit0_value", rst_out, 3'b110);
        wait_cond(C_BIT1, n);
        check("cold_bit1_gap", n, 2);
        check("cold_bit1_value", rst_out, 3'b100);
        wait_cond(C_BIT2, n);
        check("cold_bit2_gap", n, 2);
        check("cold_ready_not_yet", ready, 0);
        wait_cond(C_READY, n);
        check("cold_ready_delay", n, 1);
        check("cold_relock", relock_count, 0);
        check("cold_pll_rst_low", pll_rst, 0);

        // Loss of lock in RUN, then a normal relock.
        locked = 1'b0;
        wait_cond(C_READY_LO, n);
        check("loss_latency", n, 3);
        check("loss_rst_out", rst_out, 3'b111);
        check("loss_relock", relock_count, 1);
        check("loss_pll_rst", pll_rst, 1);
        wait_cond(C_PLL_LO, n);
        check("loss_pulse_width", n, 4);
        locked = 1'b1;
        wait_cond(C_READY, n);
        check("relock_ready_latency", n, 16);
        check("relock_count_kept", relock_count, 1);

        // Glitchy lock: one low cycle restarts the filter.
        do_reset();
        wait_cond(C_PLL_LO, n);
        check("glitch_pllrst_width", n, 4);
        locked = 1'b1;
        repeat (5) @(negedge clkin);
        locked = 1'b0;
        @(negedge clkin);
        locked = 1'b1;
        check("glitch_held", rst_out, 3'b111);
        wait_cond(C_BIT0, n);
        check("glitch_bit0_latency", n, 11);
        check("glitch_bit0_value", rst_out, 3'b110);

        // Mid-release loss: all stages re-asserted.
        locked = 1'b0;
        wait_cond(C_ALL_ONES, n);
        check("midrel_reassert", n, 3);
        check("midrel_relock", relock_count, 1);
        check("midrel_pll_rst", pll_rst, 1);
        check("midrel_ready", ready, 0);
        locked = 1'b1;
        wait_cond(C_BIT0, n);
        check("midrel_rerelease", n, 13);

        // rst during RELEASE wins over everything.
        rst = 1'b1;
        @(negedge clkin);
        check("relrst_pll_rst", pll_rst, 1);
        check("relrst_rst_out", rst_out, 3'b111);
        check("relrst_ready", ready, 0);
        check("relrst_fault", fault, 0);
        check("relrst_relock", relock_count, 0);

        // No lock: three pulses 100 cycles apart, then FAULT.
        do_reset();
        wait_cond(C_PLL_LO, n);
        check("nolock_pulse1", n, 4);
        wait_cond(C_PLL_HI, n);
        check("nolock_timeout1", n, 100);
        wait_cond(C_PLL_LO, n);
        check("nolock_pulse2", n, 4);
        wait_cond(C_PLL_HI, n);
        check("nolock_timeout2", n, 100);
        wait_cond(C_PLL_LO, n);
        check("nolock_pulse3", n, 4);
        wait_cond(C_FAULT, n);
        check("nolock_timeout3", n, 100);
        check("fault_pll_rst", pll_rst, 1);
        check("fault_rst_out", rst_out, 3'b111);
        locked = 1'b1;
        repeat (40) @(negedge clkin);
        check("fault_sticky", fault, 1);
        check("fault_ready", ready, 0);
        check("fault_pll_rst_held", pll_rst, 1);
        rst = 1'b1;
        @(negedge clkin);
        check("fault_exit", fault, 0);
        check("fault_exit_pll_rst", pll_rst, 1);

        // Saturation: 260 forced losses.
        do_reset();
        loop_ok = 1'b1;
        for (int i = 0; i < 260; i++) begin
            locked = 1'b1;
            wait_cond(C_BIT0, n);
            if (n >= BUDGET) loop_ok = 1'b0;
            locked = 1'b0;
            wait_cond(C_ALL_ONES, n);
            if (n >= BUDGET) loop_ok = 1'b0;
            if (i == 199) check("sat_count_200", relock_count, 200);
        end
        check("sat_loop_progress", loop_ok, 1);
        check("sat_relock_255", relock_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
